// File: rtl/pipelined_processor_param.sv
// Three-stage (decode / execute / writeback) core, parameterised register file and ALU; FORWARD_EN adds EX->decode forwarding.
// Latency: an OUT accepted in cycle t drives out_data/out_valid from cycle t+3.
// Backpressure: an OUT blocked in WB freezes every stage and holds in_ready low.
module pipelined_processor_param #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REGS   = 8,
  localparam int REG_AW    = $clog2(NUM_REGS)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            in_opcode,
  input  logic [REG_AW-1:0]     in_rd,
  input  logic [REG_AW-1:0]     in_rs1,
  input  logic [REG_AW-1:0]     in_rs2,
  input  logic [DATA_WIDTH-1:0] in_imm,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  busy
);

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_MOVI = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_OR   = 3'b101;
  localparam logic [2:0] OP_XOR  = 3'b110;
  localparam logic [2:0] OP_OUT  = 3'b111;

  function automatic logic writes_rd(input logic [2:0] op);
    return (op != OP_NOP) && (op != OP_OUT);
  endfunction

  function automatic logic uses_rs1(input logic [2:0] op);
    return op >= OP_ADD;
  endfunction

  function automatic logic uses_rs2(input logic [2:0] op);
    return (op >= OP_ADD) && (op != OP_OUT);
  endfunction

  logic [DATA_WIDTH-1:0] rf [NUM_REGS];

  // ID->EX stage register
  logic                  ex_vld;
  logic [2:0]            ex_op;
  logic [REG_AW-1:0]     ex_rd;
  logic [DATA_WIDTH-1:0] ex_a;
  logic [DATA_WIDTH-1:0] ex_b;
  logic [DATA_WIDTH-1:0] ex_imm;

  // EX->WB stage register
  logic                  wb_vld;
  logic [2:0]            wb_op;
  logic [REG_AW-1:0]     wb_rd;
  logic [DATA_WIDTH-1:0] wb_res;

  logic [DATA_WIDTH-1:0] alu_res;
  logic [DATA_WIDTH-1:0] opa;
  logic [DATA_WIDTH-1:0] opb;
  logic                  ex_wr;
  logic                  wb_wr;
  logic                  freeze;
  logic                  hazard_stall;
  logic                  accept;

  assign ex_wr  = ex_vld && writes_rd(ex_op);
  assign wb_wr  = wb_vld && writes_rd(wb_op);
  // An OUT in WB may only retire once the previous value has been taken.
  assign freeze = wb_vld && (wb_op == OP_OUT) && out_valid && !out_ready;

  // EX-stage ALU; arithmetic wraps at DATA_WIDTH.
  always_comb begin
    alu_res = '0;
    case (ex_op)
      OP_MOVI: alu_res = ex_imm;
      OP_ADD:  alu_res = ex_a + ex_b;
      OP_SUB:  alu_res = ex_a - ex_b;
      OP_AND:  alu_res = ex_a & ex_b;
      OP_OR:   alu_res = ex_a | ex_b;
      OP_XOR:  alu_res = ex_a ^ ex_b;
      OP_OUT:  alu_res = ex_a;
      default: alu_res = '0;
    endcase
  end

  // Decode operand read: WB write-through, then EX forwarding (newer) when enabled.
  always_comb begin
    opa = rf[in_rs1];
    opb = rf[in_rs2];
    if (wb_wr && (wb_rd == in_rs1)) opa = wb_res;
    if (wb_wr && (wb_rd == in_rs2)) opb = wb_res;
`ifdef FORWARD_EN
    if (ex_wr && (ex_rd == in_rs1)) opa = alu_res;
    if (ex_wr && (ex_rd == in_rs2)) opb = alu_res;
`endif
  end

`ifdef FORWARD_EN
  assign hazard_stall = 1'b0;
`else
  assign hazard_stall = in_valid && ex_wr &&
                        ((uses_rs1(in_opcode) && (in_rs1 == ex_rd)) ||
                         (uses_rs2(in_opcode) && (in_rs2 == ex_rd)));
`endif

  assign in_ready = reset && !freeze && !hazard_stall;
  assign accept   = in_valid && in_ready;
  assign busy     = ex_vld || wb_vld;

  // Advance the pipeline; a stall or idle input becomes a bubble in EX.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ex_vld <= 1'b0;
      ex_op  <= OP_NOP;
      ex_rd  <= '0;
      ex_a   <= '0;
      ex_b   <= '0;
      ex_imm <= '0;
      wb_vld <= 1'b0;
      wb_op  <= OP_NOP;
      wb_rd  <= '0;
      wb_res <= '0;
    end else if (!freeze) begin
      ex_vld <= accept;
      if (accept) begin
        ex_op  <= in_opcode;
        ex_rd  <= in_rd;
        ex_a   <= opa;
        ex_b   <= opb;
        ex_imm <= in_imm;
      end
      wb_vld <= ex_vld;
      wb_op  <= ex_op;
      wb_rd  <= ex_rd;
      wb_res <= alu_res;
    end
  end

  // Register file write at the end of WB.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) rf[i] <= '0;
    end else if (wb_wr && !freeze) begin
      rf[wb_rd] <= wb_res;
    end
  end

  // Output register: a retiring OUT replaces the value, otherwise a handshake clears it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (wb_vld && (wb_op == OP_OUT) && !freeze) begin
      out_valid <= 1'b1;
      out_data  <= wb_res;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pipelined_processor_param.sv
`timescale 1ns/1ps
module tb_pipelined_processor_param;

`ifdef FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset;
  logic       in_valid, in_ready, out_valid, out_ready, busy;
  logic [2:0] in_opcode, in_rd, in_rs1, in_rs2;
  logic [7:0] in_imm, out_data;

  logic        w_in_valid, w_in_ready, w_out_valid, w_out_ready, w_busy;
  logic [2:0]  w_opcode;
  logic [3:0]  w_rd, w_rs1, w_rs2;
  logic [15:0] w_imm, w_out_data;

  pipelined_processor_param u_dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  pipelined_processor_param #(.DATA_WIDTH(16), .NUM_REGS(16)) u_wide (
    .clock(clock), .reset(reset),
    .in_valid(w_in_valid), .in_ready(w_in_ready), .in_opcode(w_opcode),
    .in_rd(w_rd), .in_rs1(w_rs1), .in_rs2(w_rs2), .in_imm(w_imm),
    .out_valid(w_out_valid), .out_ready(w_out_ready), .out_data(w_out_data), .busy(w_busy)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int acc_cyc  = 0;

  // Architectural model: register values and the in-order list of values OUT must emit.
  logic [7:0] m_reg [8];
  logic [7:0] exp_q [$];
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data  = 8'd0;

  always @(posedge clock) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 8; i++) m_reg[i] = 8'd0;
    exp_q.delete();
  endtask

  // Scoreboard: mirror each accepted instruction in the model, check every emitted value and hold stability.
  always @(negedge clock) begin
    if (!reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_data", 32'(out_data), 32'(prev_data));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_out: got 0x%0h expected no output", out_data);
        end else begin
          check("out_data", 32'(out_data), 32'(exp_q.pop_front()));
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      if (in_valid && in_ready) begin
        case (in_opcode)
          3'd1: m_reg[in_rd] = in_imm;
          3'd2: m_reg[in_rd] = m_reg[in_rs1] + m_reg[in_rs2];
          3'd3: m_reg[in_rd] = m_reg[in_rs1] - m_reg[in_rs2];
          3'd4: m_reg[in_rd] = m_reg[in_rs1] & m_reg[in_rs2];
          3'd5: m_reg[in_rd] = m_reg[in_rs1] | m_reg[in_rs2];
          3'd6: m_reg[in_rd] = m_reg[in_rs1] ^ m_reg[in_rs2];
          3'd7: exp_q.push_back(m_reg[in_rs1]);
          default: ;
        endcase
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Present one instruction and hold it until accepted; acc_cyc records the accepting cycle.
  task automatic issue(input bit wide, input logic [2:0] op, input logic [3:0] rd,
                       input logic [3:0] rs1, input logic [3:0] rs2, input logic [15:0] imm);
    int w = 0;
    if (wide) begin
      w_in_valid = 1'b1; w_opcode = op; w_rd = rd; w_rs1 = rs1; w_rs2 = rs2; w_imm = imm;
    end else begin
      in_valid = 1'b1; in_opcode = op; in_rd = rd[2:0]; in_rs1 = rs1[2:0];
      in_rs2 = rs2[2:0]; in_imm = imm[7:0];
    end
    @(negedge clock);
    while (!(wide ? w_in_ready : in_ready) && w < 40) begin
      @(negedge clock);
      w++;
    end
    if (!(wide ? w_in_ready : in_ready)) begin
      n_checks++;
      n_fail++;
      $display("FAIL issue_timeout: got in_ready=0 for 40 cycles expected acceptance of op %0d", op);
    end
    acc_cyc = cyc;
    @(posedge clock);
    #1;
    in_valid   = 1'b0;
    w_in_valid = 1'b0;
  endtask

  task automatic wait_out(input bit wide, output int c, output logic [15:0] d);
    int w = 0;
    @(negedge clock);
    while (!(wide ? w_out_valid : out_valid) && w < 40) begin
      @(negedge clock);
      w++;
    end
    if (!(wide ? w_out_valid : out_valid)) begin
      n_checks++;
      n_fail++;
      $display("FAIL out_timeout: got out_valid=0 for 40 cycles expected 1");
    end
    c = cyc;
    d = wide ? w_out_data : {8'd0, out_data};
  endtask

  initial begin
    int c0, c2, c3, cv;
    logic [15:0] d;
    bit acc_prev;

    reset = 1'b0;
    in_valid = 1'b0; in_opcode = 3'd0; in_rd = 3'd0; in_rs1 = 3'd0; in_rs2 = 3'd0; in_imm = 8'd0;
    out_ready = 1'b1;
    w_in_valid = 1'b0; w_opcode = 3'd0; w_rd = 4'd0; w_rs1 = 4'd0; w_rs2 = 4'd0; w_imm = 16'd0;
    w_out_ready = 1'b1;
    model_clear();

    repeat (2) @(negedge clock);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_wide_busy", 32'(w_busy), 32'd0);
    @(posedge clock);
    #1 reset = 1'b1;
    idle(2);

    // Dependency chain: MOVI r1,200; MOVI r2,100; ADD r3,r1,r2; OUT r3
    issue(0, 3'd1, 4'd1, 4'd0, 4'd0, 16'd200); c0 = acc_cyc;
    issue(0, 3'd1, 4'd2, 4'd0, 4'd0, 16'd100);
    issue(0, 3'd2, 4'd3, 4'd1, 4'd2, 16'd0);   c2 = acc_cyc;
    issue(0, 3'd7, 4'd0, 4'd3, 4'd0, 16'd0);   c3 = acc_cyc;
    wait_out(0, cv, d);
    check("chain_add_accept_cycle", 32'(c2 - c0), FWD ? 32'd2 : 32'd3);
    check("chain_out_accept_cycle", 32'(c3 - c0), FWD ? 32'd3 : 32'd5);
    check("chain_out_valid_cycle", 32'(cv - c0), FWD ? 32'd6 : 32'd8);
    check("chain_data", 32'(d), 32'd44);

    // Backpressure: two OUTs with the consumer stalled, then release.
    idle(4);
    out_ready = 1'b0;
    issue(0, 3'd7, 4'd0, 4'd1, 4'd0, 16'd0);
    issue(0, 3'd7, 4'd0, 4'd2, 4'd0, 16'd0);
    in_valid = 1'b1; in_opcode = 3'd0; in_rd = 3'd0; in_rs1 = 3'd0; in_rs2 = 3'd0;
    idle(5);
    @(negedge clock);
    check("bp_valid", 32'(out_valid), 32'd1);
    check("bp_data_held", 32'(out_data), 32'd200);
    check("bp_in_ready", 32'(in_ready), 32'd0);
    check("bp_busy", 32'(busy), 32'd1);
    @(posedge clock);
    #1 out_ready = 1'b1;
    @(negedge clock);
    check("bp_first_taken", 32'(out_data), 32'd200);
    @(posedge clock);
    #1 in_valid = 1'b0;
    @(negedge clock);
    check("bp_second_valid", 32'(out_valid), 32'd1);
    check("bp_second_data", 32'(out_data), 32'd100);

    // SUB underflow and XOR self-clear.
    idle(4);
    issue(0, 3'd1, 4'd0, 4'd0, 4'd0, 16'd5);
    issue(0, 3'd1, 4'd1, 4'd0, 4'd0, 16'd7);
    issue(0, 3'd3, 4'd2, 4'd0, 4'd1, 16'd0);
    issue(0, 3'd7, 4'd0, 4'd2, 4'd0, 16'd0);
    wait_out(0, cv, d);
    check("sub_underflow", 32'(d), 32'd254);
    idle(3);
    issue(0, 3'd6, 4'd4, 4'd2, 4'd2, 16'd0);
    issue(0, 3'd7, 4'd0, 4'd4, 4'd0, 16'd0);
    wait_out(0, cv, d);
    check("xor_self", 32'(d), 32'd0);

    // Write-through: ADD r1,r1,r1 in WB while OUT r1 decodes behind a NOP.
    idle(4);
    issue(0, 3'd1, 4'd1, 4'd0, 4'd0, 16'd3);
    idle(3);
    issue(0, 3'd2, 4'd1, 4'd1, 4'd1, 16'd0); c0 = acc_cyc;
    issue(0, 3'd0, 4'd0, 4'd0, 4'd0, 16'd0);
    issue(0, 3'd7, 4'd0, 4'd1, 4'd0, 16'd0); c3 = acc_cyc;
    wait_out(0, cv, d);
    check("wt_no_stall", 32'(c3 - c0), 32'd2);
    check("wt_data", 32'(d), 32'd6);

    // Reset mid-run with EX and WB occupied and an output pending.
    idle(4);
    issue(0, 3'd7, 4'd0, 4'd1, 4'd0, 16'd0);
    issue(0, 3'd1, 4'd6, 4'd0, 4'd0, 16'd9);
    issue(0, 3'd1, 4'd5, 4'd0, 4'd0, 16'd4);
    check("pre_reset_busy", 32'(busy), 32'd1);
    check("pre_reset_out_valid", 32'(out_valid), 32'd1);
    reset = 1'b0;
    #1;
    check("mid_reset_busy", 32'(busy), 32'd0);
    check("mid_reset_out_valid", 32'(out_valid), 32'd0);
    check("mid_reset_out_data", 32'(out_data), 32'd0);
    check("mid_reset_in_ready", 32'(in_ready), 32'd0);
    model_clear();
    idle(2);
    reset = 1'b1;
    idle(2);
    issue(0, 3'd7, 4'd0, 4'd5, 4'd0, 16'd0);
    issue(0, 3'd7, 4'd0, 4'd1, 4'd0, 16'd0);
    wait_out(0, cv, d);
    check("post_reset_r5", 32'(d), 32'd0);
    wait_out(0, cv, d);
    check("post_reset_r1", 32'(d), 32'd0);

    // 16-bit / 16-register instance.
    issue(1, 3'd1, 4'd15, 4'd0, 4'd0, 16'hFFFF);
    issue(1, 3'd1, 4'd14, 4'd0, 4'd0, 16'h0001);
    issue(1, 3'd2, 4'd13, 4'd15, 4'd14, 16'h0000);
    issue(1, 3'd7, 4'd0, 4'd13, 4'd0, 16'h0000);
    wait_out(1, cv, d);
    check("wide_add_wrap", 32'(d), 32'h0000);
    idle(3);
    issue(1, 3'd7, 4'd0, 4'd15, 4'd0, 16'h0000);
    wait_out(1, cv, d);
    check("wide_full_value", 32'(d), 32'hFFFF);

    // Randomised traffic with random consumer backpressure; the scoreboard checks every output.
    idle(3);
    acc_prev = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if (!in_valid || acc_prev) begin
        in_valid  = ($urandom_range(0, 9) < 7);
        in_opcode = 3'($urandom_range(0, 7));
        in_rd     = 3'($urandom_range(0, 7));
        in_rs1    = 3'($urandom_range(0, 7));
        in_rs2    = 3'($urandom_range(0, 7));
        in_imm    = 8'($urandom_range(0, 255));
      end
      out_ready = ($urandom_range(0, 9) < 6);
      @(negedge clock);
      acc_prev = in_valid && in_ready;
      @(posedge clock);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    idle(20);
    check("drain_all_outputs", 32'(exp_q.size()), 32'd0);
    check("drain_busy", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
